// File: rtl/fetch_unit_pkg.sv
// Shared ISA-level constants and types for the instruction fetch path.
package fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // Load/store width encodings, shared with the memory block.
    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; low address bits of a target are ignored.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: dual instruction read ports, redirect and decode handshake.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [XLEN-1:0] mem_addr1;
    logic [XLEN-1:0] mem_addr2;
    logic            mem_en2;
    logic [XLEN-1:0] mem_data1;
    logic [XLEN-1:0] mem_data2;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;

    // The fetch unit drives addresses and the decode-side valid/data.
    modport master (
        output mem_addr1, mem_addr2, mem_en2,
        input  mem_data1, mem_data2,
        input  redirect, redirect_pc,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready
    );

    // Memory, branch unit and decode see the mirror image.
    modport slave (
        input  mem_addr1, mem_addr2, mem_en2,
        output mem_data1, mem_data2,
        output redirect, redirect_pc,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// Circular instruction buffer with two in-order write ports and one read port.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int QDEPTH = 4,
    localparam int PTR_W = $clog2(QDEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr0_en,
    input  fetch_entry_t       wr0_entry,
    input  logic               wr1_en,
    input  fetch_entry_t       wr1_entry,
    input  logic               rd_en,
    output logic               rd_valid,
    output fetch_entry_t       rd_entry,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     storage [QDEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       n_push;
    logic             do_pop;
    logic [PTR_W-1:0] wr1_ptr;
    logic [CNT_W:0]   count_after;

    // Port 1 lands right behind port 0 when both write, otherwise at the tail.
    always_comb begin
        n_push      = {1'b0, wr0_en} + {1'b0, wr1_en};
        do_pop      = rd_en && rd_valid;
        wr1_ptr     = tail + PTR_W'(wr0_en);
        count_after = {1'b0, count_q} + (CNT_W+1)'(n_push) - (CNT_W+1)'(do_pop);
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PTR_W'(do_pop);
            tail    <= tail + PTR_W'(n_push);
            count_q <= count_after[CNT_W-1:0];
        end
    end

    // Entry storage needs no reset since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            if (wr0_en) storage[tail]    <= wr0_entry;
            if (wr1_en) storage[wr1_ptr] <= wr1_entry;
        end
    end

    // Head is only presented while something is buffered.
    always_comb begin
        rd_valid = (count_q != '0);
        rd_entry = rd_valid ? storage[head] : '0;
        count    = count_q;
    end

    // The issue logic upstream must never let the buffer overfill.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n || flush)
        count_after <= (CNT_W+1)'(QDEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: dual sequential fetch, response capture, redirect and decode hand-off.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  infl_pc;
    logic [1:0]       inflight;
    logic [1:0]       infl_cnt;
    logic [CNT_W-1:0] q_count;
    logic [31:0]      free_slots;
    logic             issue_two;
    logic             issue_one;
    logic             q_valid;
    fetch_entry_t     q_head;
    fetch_entry_t     wr0_entry;
    fetch_entry_t     wr1_entry;

    // Space left once everything already requested has landed; pops are not credited.
    always_comb begin
        infl_cnt   = {1'b0, inflight[0]} + {1'b0, inflight[1]};
        free_slots = 32'(QDEPTH) - 32'(q_count) - 32'(infl_cnt);
        issue_two  = rst_n && !bus.redirect && (free_slots >= 32'd2);
        issue_one  = rst_n && !bus.redirect && (free_slots == 32'd1);
    end

    // Fetch PC and in-flight tracking; redirect discards anything outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            infl_pc  <= RESET_PC;
            inflight <= 2'b00;
        end else if (bus.redirect) begin
            pc       <= align_pc(bus.redirect_pc);
            infl_pc  <= pc;
            inflight <= 2'b00;
        end else begin
            infl_pc <= pc;
            if (issue_two) begin
                pc       <= pc + XLEN'(2 * INSTR_BYTES);
                inflight <= 2'b11;
            end else if (issue_one) begin
                pc       <= pc + XLEN'(INSTR_BYTES);
                inflight <= 2'b01;
            end else begin
                inflight <= 2'b00;
            end
        end
    end

    // Returned words are tagged with the PCs they were requested from.
    always_comb begin
        wr0_entry.pc    = infl_pc;
        wr0_entry.instr = bus.mem_data1;
        wr1_entry.pc    = infl_pc + XLEN'(INSTR_BYTES);
        wr1_entry.instr = bus.mem_data2;
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect),
        .wr0_en    (inflight[0]),
        .wr0_entry (wr0_entry),
        .wr1_en    (inflight[1]),
        .wr1_entry (wr1_entry),
        .rd_en     (bus.dec_ready),
        .rd_valid  (q_valid),
        .rd_entry  (q_head),
        .count     (q_count)
    );

    // Memory addresses come straight from the PC register; decode sees the queue head.
    always_comb begin
        bus.mem_addr1 = pc;
        bus.mem_addr2 = pc + XLEN'(INSTR_BYTES);
        bus.mem_en2   = issue_two;
        bus.dec_valid = q_valid;
        bus.dec_instr = q_head.instr;
        bus.dec_pc    = q_head.pc;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC streams are queued on reset/redirect.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad = 0;
    int          pop_count = 0;
    logic [31:0] sb_q [$];

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference ROM contents: word at byte address a.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        return 32'h1111_1111 * ((a >> 2) + 32'd1);
    endfunction

    // Synchronous dual-port instruction memory; port 2 returns junk unless enabled.
    always @(posedge clk) begin
        bus.mem_data1 <= romWord(bus.mem_addr1);
        bus.mem_data2 <= bus.mem_en2 ? romWord(bus.mem_addr2) : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) nextCycle();
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic redir,
                                 input logic [31:0] rpc);
        rst_n           = rst;
        bus.dec_ready   = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        #1;
    endtask

    // Expected decode order after a (re)start: sequential words from the aligned target.
    task automatic setStream(input logic [31:0] start);
        logic [31:0] base;
        base = {start[31:2], 2'b00};
        sb_q.delete();
        for (int i = 0; i < 64; i++) sb_q.push_back(base + 32'(i * 4));
    endtask

    task automatic waitValid(input int max_cycles);
        int n = 0;
        while (!bus.dec_valid && n < max_cycles) begin
            nextCycle();
            n++;
        end
        checkOutput("wait_valid", {31'd0, bus.dec_valid}, 32'd1);
    endtask

    // Every accepted instruction is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1) begin
            pop_count++;
            if (sb_q.size() == 0) begin
                checkOutput("sb_empty", 32'd1, 32'd0);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = sb_q.pop_front();
                checkOutput("dec_pc", bus.dec_pc, exp_pc);
                checkOutput("dec_instr", bus.dec_instr, romWord(exp_pc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic found;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        runCycles(2);

        // Reset state
        checkOutput("rst_valid", {31'd0, bus.dec_valid}, 32'd0);
        checkOutput("rst_en2", {31'd0, bus.mem_en2}, 32'd0);
        checkOutput("rst_addr1", bus.mem_addr1, RESET_PC);
        checkOutput("rst_pc", bus.dec_pc, 32'd0);
        checkOutput("rst_instr", bus.dec_instr, 32'd0);

        // Streaming from reset with decode always ready
        setStream(RESET_PC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("a_c0_addr1", bus.mem_addr1, 32'h0);
        checkOutput("a_c0_addr2", bus.mem_addr2, 32'h4);
        checkOutput("a_c0_en2", {31'd0, bus.mem_en2}, 32'd1);
        checkOutput("a_c0_valid", {31'd0, bus.dec_valid}, 32'd0);
        nextCycle();
        checkOutput("a_c1_addr1", bus.mem_addr1, 32'h8);
        checkOutput("a_c1_en2", {31'd0, bus.mem_en2}, 32'd1);
        checkOutput("a_c1_valid", {31'd0, bus.dec_valid}, 32'd0);
        nextCycle();
        checkOutput("a_c2_valid", {31'd0, bus.dec_valid}, 32'd1);
        checkOutput("a_c2_pc", bus.dec_pc, 32'h0);
        runCycles(20);

        // Back-pressure from reset: two, two, then no issue
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        nextCycle();
        setStream(RESET_PC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("b_c0_en2", {31'd0, bus.mem_en2}, 32'd1);
        checkOutput("b_c0_addr1", bus.mem_addr1, 32'h0);
        nextCycle();
        checkOutput("b_c1_en2", {31'd0, bus.mem_en2}, 32'd1);
        checkOutput("b_c1_addr1", bus.mem_addr1, 32'h8);
        for (int c = 2; c < 6; c++) begin
            nextCycle();
            checkOutput("b_hold_en2", {31'd0, bus.mem_en2}, 32'd0);
            checkOutput("b_hold_addr1", bus.mem_addr1, 32'h10);
            checkOutput("b_hold_valid", {31'd0, bus.dec_valid}, 32'd1);
            checkOutput("b_hold_pc", bus.dec_pc, 32'h0);
        end

        // Single pop leaves count=3 with nothing in flight: exactly one word issued
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("c3_en2", {31'd0, bus.mem_en2}, 32'd0);
        checkOutput("c3_addr1", bus.mem_addr1, 32'h10);
        nextCycle();
        checkOutput("c3_next_addr1", bus.mem_addr1, 32'h14);
        checkOutput("c3_next_en2", {31'd0, bus.mem_en2}, 32'd0);
        nextCycle();
        checkOutput("c4_addr1", bus.mem_addr1, 32'h14);
        checkOutput("c4_en2", {31'd0, bus.mem_en2}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        runCycles(20);

        // Redirect to an unaligned target while two fetches are in flight
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        nextCycle();
        setStream(RESET_PC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("r_c0_en2", {31'd0, bus.mem_en2}, 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h103);
        checkOutput("r_redir_en2", {31'd0, bus.mem_en2}, 32'd0);
        checkOutput("r_redir_valid", {31'd0, bus.dec_valid}, 32'd0);
        nextCycle();
        setStream(32'h103);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("r_addr1", bus.mem_addr1, 32'h100);
        checkOutput("r_en2", {31'd0, bus.mem_en2}, 32'd1);
        checkOutput("r_valid1", {31'd0, bus.dec_valid}, 32'd0);
        nextCycle();
        checkOutput("r_valid2", {31'd0, bus.dec_valid}, 32'd0);
        nextCycle();
        checkOutput("r_valid3", {31'd0, bus.dec_valid}, 32'd1);
        checkOutput("r_first_pc", bus.dec_pc, 32'h100);
        runCycles(16);

        // Redirect coinciding with an accepted pop, to a target that wraps the address space
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            nextCycle();
            found = bus.dec_valid;
        end
        checkOutput("d_pre_valid", {31'd0, found}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFD);
        nextCycle();
        setStream(32'hFFFF_FFFD);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("d_valid1", {31'd0, bus.dec_valid}, 32'd0);
        checkOutput("d_addr1", bus.mem_addr1, 32'hFFFF_FFFC);
        checkOutput("d_addr2_wrap", bus.mem_addr2, 32'h0);
        checkOutput("d_en2", {31'd0, bus.mem_en2}, 32'd1);
        nextCycle();
        checkOutput("d_valid2", {31'd0, bus.dec_valid}, 32'd0);
        nextCycle();
        checkOutput("d_valid3", {31'd0, bus.dec_valid}, 32'd1);
        checkOutput("d_first_pc", bus.dec_pc, 32'hFFFF_FFFC);
        runCycles(10);

        // One-cycle reset with a full queue
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        runCycles(6);
        checkOutput("e_full_valid", {31'd0, bus.dec_valid}, 32'd1);
        checkOutput("e_full_en2", {31'd0, bus.mem_en2}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        nextCycle();
        setStream(RESET_PC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("e_valid", {31'd0, bus.dec_valid}, 32'd0);
        checkOutput("e_addr1", bus.mem_addr1, RESET_PC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        waitValid(5);
        checkOutput("e_first_pc", bus.dec_pc, RESET_PC);
        runCycles(10);

        checkOutput("pops_seen", {31'd0, (pop_count >= 20)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
